// File: rtl/tape_byte_assembler.sv
// Assembles the tape bit stream into MSB-first bytes, tags the flag byte,
// tracks the XOR checksum and closes a block after a bit-gap timeout.
module tape_byte_assembler #(
  parameter int CLK_FREQ      = 27000000,
  parameter int TIMEOUT_TICKS = 54000,
  parameter int COUNT_W       = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               arm,
  input  logic               bit_in,
  input  logic               bit_valid,
  output logic [7:0]         byte_out,
  output logic               byte_valid,
  output logic [COUNT_W-1:0] byte_index,
  output logic               is_flag,
  output logic               busy,
  output logic               block_done,
  output logic [COUNT_W-1:0] byte_count,
  output logic               checksum_ok,
  output logic               bit_error
);

  localparam int TIMER_W = $clog2(TIMEOUT_TICKS + 1);

  typedef enum logic [1:0] {IDLE, FLAG, DATA, DONE} state_t;

  state_t               state_q, state_d;
  logic [6:0]           shift_q, shift_d;
  logic [2:0]           bitCnt_q, bitCnt_d;
  logic [7:0]           chk_q, chk_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [COUNT_W-1:0]   byteCnt_q, byteCnt_d;
  logic [7:0]           byteOut_q, byteOut_d;
  logic                 byteValid_q, byteValid_d;
  logic [COUNT_W-1:0]   byteIndex_q, byteIndex_d;
  logic                 isFlag_q, isFlag_d;
  logic                 blockDone_q, blockDone_d;
  logic [COUNT_W-1:0]   byteCount_q, byteCount_d;
  logic                 checksumOk_q, checksumOk_d;
  logic                 bitError_q, bitError_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      bitCnt_q     <= '0;
      chk_q        <= '0;
      timer_q      <= '0;
      byteCnt_q    <= '0;
      byteOut_q    <= '0;
      byteValid_q  <= 1'b0;
      byteIndex_q  <= '0;
      isFlag_q     <= 1'b0;
      blockDone_q  <= 1'b0;
      byteCount_q  <= '0;
      checksumOk_q <= 1'b0;
      bitError_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bitCnt_q     <= bitCnt_d;
      chk_q        <= chk_d;
      timer_q      <= timer_d;
      byteCnt_q    <= byteCnt_d;
      byteOut_q    <= byteOut_d;
      byteValid_q  <= byteValid_d;
      byteIndex_q  <= byteIndex_d;
      isFlag_q     <= isFlag_d;
      blockDone_q  <= blockDone_d;
      byteCount_q  <= byteCount_d;
      checksumOk_q <= checksumOk_d;
      bitError_q   <= bitError_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bitCnt_d     = bitCnt_q;
    chk_d        = chk_q;
    timer_d      = timer_q;
    byteCnt_d    = byteCnt_q;
    byteOut_d    = byteOut_q;
    byteValid_d  = 1'b0;
    byteIndex_d  = byteIndex_q;
    isFlag_d     = isFlag_q;
    blockDone_d  = 1'b0;
    byteCount_d  = byteCount_q;
    checksumOk_d = checksumOk_q;
    bitError_d   = bitError_q;

    if (state_q == DONE) begin
      // Report the finished block even when a new arm arrives in this cycle.
      blockDone_d  = 1'b1;
      byteCount_d  = byteCnt_q;
      checksumOk_d = (chk_q == 8'h00) && (byteCnt_q >= COUNT_W'(2));
      bitError_d   = (bitCnt_q != 3'd0);
      state_d      = IDLE;
      if (arm) begin
        state_d   = FLAG;
        shift_d   = '0;
        bitCnt_d  = '0;
        chk_d     = '0;
        timer_d   = '0;
        byteCnt_d = '0;
      end
    end else if (arm) begin
      state_d      = FLAG;
      shift_d      = '0;
      bitCnt_d     = '0;
      chk_d        = '0;
      timer_d      = '0;
      byteCnt_d    = '0;
      byteCount_d  = '0;
      checksumOk_d = 1'b0;
      bitError_d   = 1'b0;
    end else if (state_q != IDLE) begin
      if (bit_valid) begin
        shift_d  = {shift_q[5:0], bit_in};
        bitCnt_d = bitCnt_q + 3'd1;
        timer_d  = '0;
        if (bitCnt_q == 3'd7) begin
          byteOut_d   = {shift_q, bit_in};
          byteValid_d = 1'b1;
          byteIndex_d = byteCnt_q;
          isFlag_d    = (state_q == FLAG);
          chk_d       = chk_q ^ {shift_q, bit_in};
          if (byteCnt_q != '1) begin
            byteCnt_d = byteCnt_q + COUNT_W'(1);
          end
          state_d = DATA;
        end
      end else if (timer_q == TIMER_W'(TIMEOUT_TICKS - 1)) begin
        state_d = DONE;
      end else if (timer_q != TIMER_W'(TIMEOUT_TICKS)) begin
        timer_d = timer_q + TIMER_W'(1);
      end
    end
  end

  assign byte_out    = byteOut_q;
  assign byte_valid  = byteValid_q;
  assign byte_index  = byteIndex_q;
  assign is_flag     = isFlag_q;
  assign busy        = (state_q == FLAG) || (state_q == DATA);
  assign block_done  = blockDone_q;
  assign byte_count  = byteCount_q;
  assign checksum_ok = checksumOk_q;
  assign bit_error   = bitError_q;

endmodule

// File: tb/tb_tape_byte_assembler.sv
// Randomised scoreboard bench for tape_byte_assembler; a short timeout keeps
// blocks compact so many of them fit in one run.
module tb_tape_byte_assembler;

  localparam int T  = 40;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset, arm, bit_in, bit_valid;
  logic [7:0]    byte_out;
  logic          byte_valid, is_flag, busy, block_done, checksum_ok, bit_error;
  logic [CW-1:0] byte_index, byte_count;

  tape_byte_assembler #(.CLK_FREQ(27000000), .TIMEOUT_TICKS(T), .COUNT_W(CW)) dut (
    .clk(clk), .reset(reset), .arm(arm), .bit_in(bit_in), .bit_valid(bit_valid),
    .byte_out(byte_out), .byte_valid(byte_valid), .byte_index(byte_index),
    .is_flag(is_flag), .busy(busy), .block_done(block_done),
    .byte_count(byte_count), .checksum_ok(checksum_ok), .bit_error(bit_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int failed = 0;

  typedef struct {logic [7:0] val; int idx; logic flag; int cyc;} byteExp_t;
  typedef struct {int cnt; logic ok; logic err; int cyc;} doneExp_t;
  byteExp_t byteQ[$];
  doneExp_t doneQ[$];

  // Reference model: the bits received since the last arm, plus idle count.
  int   mState = 0;
  int   quiet  = 0;
  logic mBits[$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic logic [7:0] byteAt(input int k);
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[7-i] = mBits[8*k + i];
    return v;
  endfunction

  function automatic doneExp_t blockSummary(input int e);
    doneExp_t d;
    logic [7:0] x;
    x = 8'h00;
    d.cnt = mBits.size() / 8;
    for (int k = 0; k < d.cnt; k++) x = x ^ byteAt(k);
    d.ok  = (x == 8'h00) && (d.cnt >= 2);
    d.err = (mBits.size() % 8) != 0;
    d.cyc = e;
    return d;
  endfunction

  // One clock of stimulus: drive at negedge, update the model for the edge
  // that samples it, then compare busy just after that edge.
  task automatic applyStimulus(input logic a, input logic bv, input logic b);
    int e;
    @(negedge clk);
    arm = a; bit_valid = bv; bit_in = b;
    e = cyc + 1;
    if (mState == 2) begin
      doneQ.push_back(blockSummary(e));
      mState = a ? 1 : 0;
      mBits.delete();
      quiet = 0;
    end else if (a) begin
      mBits.delete();
      quiet  = 0;
      mState = 1;
    end else if (mState == 1) begin
      if (bv) begin
        mBits.push_back(b);
        quiet = 0;
        if (mBits.size() % 8 == 0) begin
          byteExp_t be;
          be.idx  = mBits.size() / 8 - 1;
          be.val  = byteAt(be.idx);
          be.flag = (be.idx == 0);
          be.cyc  = e;
          byteQ.push_back(be);
        end
      end else begin
        quiet++;
        if (quiet == T) mState = 2;
      end
    end
    @(posedge clk);
    #1;
    checkOutput("busy", {31'd0, busy}, {31'd0, mState == 1});
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  task automatic sendBits(input logic [7:0] v, input int nbits, input int gapMax);
    for (int i = 7; i > 7 - nbits; i--) begin
      idle($urandom_range(0, gapMax));
      applyStimulus(1'b0, 1'b1, v[i]);
    end
  endtask

  task automatic sendByte(input logic [7:0] v, input int gapMax);
    sendBits(v, 8, gapMax);
  endtask

  // Monitor: every strobe from the DUT must match the oldest expectation.
  always @(negedge clk) begin
    if (byte_valid) begin
      if (byteQ.size() == 0) begin
        checkOutput("unexpected_byte", {24'd0, byte_out}, 32'hFFFF_FFFF);
      end else begin
        byteExp_t be;
        be = byteQ.pop_front();
        checkOutput("byte_out", {24'd0, byte_out}, {24'd0, be.val});
        checkOutput("byte_index", {16'd0, byte_index}, be.idx);
        checkOutput("is_flag", {31'd0, is_flag}, {31'd0, be.flag});
        checkOutput("byte_cycle", cyc, be.cyc);
      end
    end
    if (block_done) begin
      if (doneQ.size() == 0) begin
        checkOutput("unexpected_done", {16'd0, byte_count}, 32'hFFFF_FFFF);
      end else begin
        doneExp_t de;
        de = doneQ.pop_front();
        checkOutput("byte_count", {16'd0, byte_count}, de.cnt);
        checkOutput("checksum_ok", {31'd0, checksum_ok}, {31'd0, de.ok});
        checkOutput("bit_error", {31'd0, bit_error}, {31'd0, de.err});
        checkOutput("done_cycle", cyc, de.cyc);
      end
    end
  end

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_byte_out"}, {24'd0, byte_out}, 0);
    checkOutput({tag, "_byte_valid"}, {31'd0, byte_valid}, 0);
    checkOutput({tag, "_byte_index"}, {16'd0, byte_index}, 0);
    checkOutput({tag, "_is_flag"}, {31'd0, is_flag}, 0);
    checkOutput({tag, "_busy"}, {31'd0, busy}, 0);
    checkOutput({tag, "_block_done"}, {31'd0, block_done}, 0);
    checkOutput({tag, "_byte_count"}, {16'd0, byte_count}, 0);
    checkOutput({tag, "_checksum_ok"}, {31'd0, checksum_ok}, 0);
    checkOutput({tag, "_bit_error"}, {31'd0, bit_error}, 0);
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0] v;
    reset = 1'b1; arm = 1'b0; bit_in = 1'b0; bit_valid = 1'b0;
    #1;
    checkAllZero("reset");
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // Good block, then the same block with a corrupted last byte.
    applyStimulus(1'b1, 1'b0, 1'b0);
    sendByte(8'hFF, 20); sendByte(8'h12, 20); sendByte(8'hED, 20);
    idle(T + 3);
    applyStimulus(1'b1, 1'b0, 1'b0);
    sendByte(8'hFF, 20); sendByte(8'h12, 20); sendByte(8'hEC, 20);
    idle(T + 3);

    // Two zero bytes plus a 3-bit tail.
    applyStimulus(1'b1, 1'b0, 1'b0);
    sendByte(8'h00, 10); sendByte(8'h00, 10); sendBits(8'hA0, 3, 10);
    idle(T + 3);

    // Gaps right at the timeout boundary, then a gap that ends the block.
    applyStimulus(1'b1, 1'b0, 1'b0);
    idle(T - 2); applyStimulus(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) begin
      idle(T - 1);
      applyStimulus(1'b0, 1'b1, (i == 6));
    end
    idle(T + 2);

    // Zero-byte block.
    applyStimulus(1'b1, 1'b0, 1'b0);
    idle(T + 2);

    // Abort after five bytes, with the re-arm colliding with a completing byte.
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (5) sendByte(8'($urandom), 6);
    v = 8'($urandom);
    sendBits(v, 7, 6);
    idle(2);
    applyStimulus(1'b1, 1'b1, v[0]);
    sendByte(8'h55, 6); sendByte(8'h55, 6);
    idle(T + 2);

    // Arm arriving in the block-done cycle starts the next block directly.
    applyStimulus(1'b1, 1'b0, 1'b0);
    sendByte(8'hA7, 6); sendByte(8'hA7, 6);
    idle(T);
    applyStimulus(1'b1, 1'b0, 1'b0);
    sendByte(8'h3C, 6);
    idle(T + 2);

    // Random blocks.
    for (int b = 0; b < 8; b++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      repeat ($urandom_range(0, 4)) sendByte(8'($urandom), 15);
      sendBits(8'($urandom), $urandom_range(0, 7), 15);
      idle(T + $urandom_range(1, 5));
    end

    // Reset in the middle of the second byte discards the block.
    applyStimulus(1'b1, 1'b0, 1'b0);
    sendByte(8'hA5, 5);
    sendBits(8'h96, 4, 5);
    @(negedge clk);
    arm = 1'b0; bit_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    checkAllZero("midreset");
    mState = 0; quiet = 0; mBits.delete();
    @(negedge clk);
    reset = 1'b0;

    // Bits without an arm must be ignored.
    repeat (2) sendByte(8'($urandom), 3);
    idle(T + 5);

    checkOutput("byteQ_empty", byteQ.size(), 0);
    checkOutput("doneQ_empty", doneQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
